// File: rtl/vram_scan_arbiter.sv
// Arbitrates a single-port video RAM between display scan-out and buffered CPU pixel writes.
// Scan reads always win during active video; queued CPU writes retire one per blanking cycle.
module vram_scan_arbiter #(
    parameter int H      = 640,
    parameter int V      = 480,
    parameter int SCALE  = 2,
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 8,
    parameter int FIFO_D = 4
) (
    input  logic              clk_25M,
    input  logic              rst_n,
    input  logic              draw,
    input  logic [31:0]       hPos,
    input  logic [31:0]       vPos,
    input  logic              cpu_wr_valid,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [PIX_W-1:0]  cpu_wr_data,
    output logic              cpu_wr_ready,
    output logic              cpu_wr_err,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [PIX_W-1:0]  vram_wdata,
    output logic              vram_we,
    input  logic [PIX_W-1:0]  vram_rdata,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              pixel_valid
);
    // state    | meaning
    // ST_IDLE  | blanking, write FIFO empty
    // ST_SCAN  | active video, VRAM owned by scan-out
    // ST_WRITE | blanking, retiring one queued CPU write per cycle

    localparam int          PTR_W    = $clog2(FIFO_D);
    localparam int          CNT_W    = PTR_W + 1;
    localparam logic [31:0] H_WORDS  = 32'(H >> SCALE);
    localparam logic [31:0] FB_WORDS = 32'((H >> SCALE) * (V >> SCALE));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0] addr_mem_q [FIFO_D];
    logic [PIX_W-1:0]  data_mem_q [FIFO_D];
    logic              err_q;
    logic              draw_q;
    logic              pix_valid_q;
    logic [PIX_W-1:0]  pix_out_q;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [PIX_W-1:0]  vram_wdata_d;
    logic              vram_we_d;

    logic [31:0]       scan_full;
    logic [ADDR_W-1:0] scan_addr;
    logic              fifo_empty;
    logic              push, enq, pop, addr_bad;

    assign scan_full  = (vPos >> SCALE) * H_WORDS + (hPos >> SCALE);
    assign scan_addr  = ADDR_W'(scan_full);

    assign fifo_empty   = (count_q == '0);
    assign cpu_wr_ready = (count_q < CNT_W'(FIFO_D));
    assign addr_bad     = (32'(cpu_wr_addr) >= FB_WORDS);
    assign push         = cpu_wr_valid & cpu_wr_ready;
    assign enq          = push & ~addr_bad;
    assign pop          = ~draw & ~fifo_empty;
    assign count_d      = count_q + CNT_W'(enq) - CNT_W'(pop);

    always_comb begin
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = '0;
        vram_we_d    = 1'b0;
        if (draw) begin
            vram_addr_d = scan_addr;
        end else if (pop) begin
            vram_addr_d  = addr_mem_q[rd_ptr_q];
            vram_wdata_d = data_mem_q[rd_ptr_q];
            vram_we_d    = 1'b1;
        end
    end

    // Gated by reset so no stray write or address reaches the macro while held in reset.
    assign vram_addr  = rst_n ? vram_addr_d  : '0;
    assign vram_wdata = rst_n ? vram_wdata_d : '0;
    assign vram_we    = rst_n & vram_we_d;

    assign cpu_wr_err  = err_q;
    assign pixel_out   = pix_out_q;
    assign pixel_valid = pix_valid_q;

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            draw_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_out_q   <= '0;
            vram_addr_q <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            err_q       <= push & addr_bad;
            draw_q      <= draw;
            pix_valid_q <= draw_q;
            pix_out_q   <= draw_q ? vram_rdata : '0;
            vram_addr_q <= vram_addr_d;
            if (enq) begin
                addr_mem_q[wr_ptr_q] <= cpu_wr_addr;
                data_mem_q[wr_ptr_q] <= cpu_wr_data;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_SCAN, ST_WRITE: begin
                    if (draw)             state_q <= ST_SCAN;
                    else if (!fifo_empty) state_q <= ST_WRITE;
                    else                  state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter: scan addressing, pixel latency, FIFO ordering/backpressure,
// bad-address discard and asynchronous reset.
module tb_vram_scan_arbiter;
    logic        clk_25M = 1'b0;
    logic        rst_n;
    logic        draw;
    logic [31:0] hPos, vPos;
    logic        cpu_wr_valid;
    logic [14:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_ready;
    logic        cpu_wr_err;
    logic [14:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata;
    logic [7:0]  pixel_out;
    logic        pixel_valid;

    int checks = 0;
    int errors = 0;

    vram_scan_arbiter dut (
        .clk_25M(clk_25M), .rst_n(rst_n), .draw(draw), .hPos(hPos), .vPos(vPos),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready), .cpu_wr_err(cpu_wr_err),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_rdata(vram_rdata), .pixel_out(pixel_out), .pixel_valid(pixel_valid)
    );

    always #20 clk_25M = ~clk_25M;

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units after the edge.
    task automatic step();
        @(posedge clk_25M);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; draw = 1'b0; hPos = '0; vPos = '0;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0; vram_rdata = '0;
        repeat (3) step();
        settle();
        checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cpu_wr_ready); end
        checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", vram_we); end
        checks++; if (vram_addr !== 15'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", vram_addr); end
        checks++; if (pixel_valid !== 1'b0 || pixel_out !== 8'h00) begin errors++; $display("FAIL reset_pixel got %b/%h exp 0/00", pixel_valid, pixel_out); end
        checks++; if (cpu_wr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", cpu_wr_err); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 15'd5; cpu_wr_data = 8'hA5;
        step();
        cpu_wr_valid = 1'b0;
        settle();
        checks++; if (vram_we !== 1'b1 || vram_addr !== 15'd5 || vram_wdata !== 8'hA5) begin errors++; $display("FAIL single_write got we=%b addr=%0d data=%h exp 1/5/a5", vram_we, vram_addr, vram_wdata); end
        checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", cpu_wr_ready); end
        step();
        settle();
        checks++; if (vram_we !== 1'b0 || vram_addr !== 15'd5) begin errors++; $display("FAIL single_after got we=%b addr=%0d exp 0/5", vram_we, vram_addr); end
    endtask

    task automatic test_scan();
        draw = 1'b1; hPos = 32'd8; vPos = 32'd4; vram_rdata = 8'h00;
        settle();
        checks++; if (vram_addr !== 15'd162 || vram_we !== 1'b0) begin errors++; $display("FAIL scan_addr_h8 got %0d we=%b exp 162 we=0", vram_addr, vram_we); end
        step();
        hPos = 32'd4; vPos = 32'd4; vram_rdata = 8'h11;
        settle();
        checks++; if (vram_addr !== 15'd161 || vram_we !== 1'b0) begin errors++; $display("FAIL scan_addr_h4 got %0d we=%b exp 161 we=0", vram_addr, vram_we); end
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL scan_lat1 got valid=%b exp 0", pixel_valid); end
        step();
        draw = 1'b0; vram_rdata = 8'h3C;
        settle();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'h11) begin errors++; $display("FAIL scan_pix0 got %b/%h exp 1/11", pixel_valid, pixel_out); end
        checks++; if (vram_addr !== 15'd161 || vram_we !== 1'b0) begin errors++; $display("FAIL scan_hold got %0d we=%b exp 161 we=0", vram_addr, vram_we); end
        step();
        vram_rdata = 8'h77;
        settle();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'h3C) begin errors++; $display("FAIL scan_pix1 got %b/%h exp 1/3c", pixel_valid, pixel_out); end
        step();
        settle();
        checks++; if (pixel_valid !== 1'b0 || pixel_out !== 8'h00) begin errors++; $display("FAIL scan_end got %b/%h exp 0/00", pixel_valid, pixel_out); end
    endtask

    task automatic test_back_to_back();
        draw = 1'b1; hPos = '0; vPos = '0;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_valid = 1'b1; cpu_wr_addr = 15'(10 + i); cpu_wr_data = 8'(8'h50 + i);
            settle();
            checks++; if (cpu_wr_ready !== (i < 4)) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, cpu_wr_ready, i < 4); end
            checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL b2b_we_draw[%0d] got %b exp 0", i, vram_we); end
            step();
        end
        cpu_wr_valid = 1'b0;
        draw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (vram_we !== 1'b1 || vram_addr !== 15'(10 + i) || vram_wdata !== 8'(8'h50 + i)) begin errors++; $display("FAIL b2b_drain[%0d] got we=%b addr=%0d data=%h exp 1/%0d/%h", i, vram_we, vram_addr, vram_wdata, 10 + i, 8'h50 + i); end
            checks++; if (cpu_wr_ready !== (i > 0)) begin errors++; $display("FAIL b2b_drain_ready[%0d] got %b exp %b", i, cpu_wr_ready, i > 0); end
            step();
        end
        settle();
        checks++; if (vram_we !== 1'b0 || cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_done got we=%b ready=%b exp 0/1", vram_we, cpu_wr_ready); end
    endtask

    task automatic test_bad_addr();
        draw = 1'b0;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 15'd19200; cpu_wr_data = 8'hEE;
        settle();
        checks++; if (cpu_wr_err !== 1'b0) begin errors++; $display("FAIL bad_pre_err got %b exp 0", cpu_wr_err); end
        step();
        cpu_wr_valid = 1'b0;
        settle();
        checks++; if (cpu_wr_err !== 1'b1 || vram_we !== 1'b0 || cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL bad_pulse got err=%b we=%b ready=%b exp 1/0/1", cpu_wr_err, vram_we, cpu_wr_ready); end
        step();
        settle();
        checks++; if (cpu_wr_err !== 1'b0 || vram_we !== 1'b0) begin errors++; $display("FAIL bad_after got err=%b we=%b exp 0/0", cpu_wr_err, vram_we); end
        cpu_wr_valid = 1'b1; cpu_wr_addr = 15'd19199; cpu_wr_data = 8'h99;
        step();
        cpu_wr_valid = 1'b0;
        settle();
        checks++; if (cpu_wr_err !== 1'b0 || vram_we !== 1'b1 || vram_addr !== 15'd19199 || vram_wdata !== 8'h99) begin errors++; $display("FAIL last_addr got err=%b we=%b addr=%0d data=%h exp 0/1/19199/99", cpu_wr_err, vram_we, vram_addr, vram_wdata); end
        step();
    endtask

    task automatic test_full_pop_push();
        draw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_wr_valid = 1'b1; cpu_wr_addr = 15'(20 + i); cpu_wr_data = 8'(8'h60 + i);
            step();
        end
        cpu_wr_addr = 15'd24; cpu_wr_data = 8'h64;
        draw = 1'b0;
        settle();
        checks++; if (cpu_wr_ready !== 1'b0 || vram_we !== 1'b1 || vram_addr !== 15'd20) begin errors++; $display("FAIL full_pop0 got ready=%b we=%b addr=%0d exp 0/1/20", cpu_wr_ready, vram_we, vram_addr); end
        step();
        settle();
        checks++; if (cpu_wr_ready !== 1'b1 || vram_addr !== 15'd21) begin errors++; $display("FAIL full_pop1 got ready=%b addr=%0d exp 1/21", cpu_wr_ready, vram_addr); end
        step();
        cpu_wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (vram_we !== 1'b1 || vram_addr !== 15'(22 + i) || vram_wdata !== 8'(8'h62 + i)) begin errors++; $display("FAIL full_drain[%0d] got we=%b addr=%0d data=%h exp 1/%0d/%h", i, vram_we, vram_addr, vram_wdata, 22 + i, 8'h62 + i); end
            step();
        end
        settle();
        checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL full_no_dup got we=%b exp 0", vram_we); end
    endtask

    task automatic test_async_reset();
        draw = 1'b1; hPos = 32'd40; vPos = 32'd8; vram_rdata = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            cpu_wr_valid = 1'b1; cpu_wr_addr = 15'(30 + i); cpu_wr_data = 8'(8'h70 + i);
            step();
        end
        cpu_wr_valid = 1'b0;
        settle();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'hC3 || cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_pre got valid=%b pix=%h ready=%b exp 1/c3/1", pixel_valid, pixel_out, cpu_wr_ready); end
        #5;
        rst_n = 1'b0;
        #1;
        checks++; if (pixel_valid !== 1'b0 || pixel_out !== 8'h00 || vram_we !== 1'b0 || vram_addr !== 15'd0 || cpu_wr_err !== 1'b0) begin errors++; $display("FAIL rst_now got valid=%b pix=%h we=%b addr=%0d err=%b exp all 0", pixel_valid, pixel_out, vram_we, vram_addr, cpu_wr_err); end
        checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cpu_wr_ready); end
        step();
        draw = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (vram_we !== 1'b0 || cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_after[%0d] got we=%b ready=%b exp 0/1", i, vram_we, cpu_wr_ready); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_scan();
        test_back_to_back();
        test_bad_addr();
        test_full_pop_push();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
